// File: rtl/mem_bus_scheduler_if.sv
// Request, response and memory-side signals of the memory bus scheduler.
// Latency: none, this is only a signal bundle.
// Backpressure: requesters hold req/addr/data until they see their grant.
interface mem_bus_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  system_flush;
    logic                  system_stall;
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  grant0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic                  rvalid0;
    logic                  err0;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic                  we_p1;
    logic [DATA_WIDTH-1:0] data_p1_wrt;
    logic                  grant1;
    logic [DATA_WIDTH-1:0] data_p1_rd;
    logic                  rvalid1;
    logic                  err1;
    logic                  mem_req_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_data_valid;

    // Scheduler side.
    modport slave (
        input  system_flush, system_stall,
        input  req0_valid, addr_p0,
        output grant0, data_p0, rvalid0, err0,
        input  req1_valid, addr_p1, we_p1, data_p1_wrt,
        output grant1, data_p1_rd, rvalid1, err1,
        output mem_req_valid, mem_addr, mem_we, mem_wdata,
        input  mem_rdata, mem_data_valid
    );

    // Requesters and memory side.
    modport master (
        output system_flush, system_stall,
        output req0_valid, addr_p0,
        input  grant0, data_p0, rvalid0, err0,
        output req1_valid, addr_p1, we_p1, data_p1_wrt,
        input  grant1, data_p1_rd, rvalid1, err1,
        input  mem_req_valid, mem_addr, mem_we, mem_wdata,
        output mem_rdata, mem_data_valid
    );
endinterface

// File: rtl/mem_bus_scheduler.sv
// Shares one memory bus between fetch (port 0, read) and MMU (port 1, read/write), one transaction at a time.
// Latency: grant is combinational in IDLE; rvalid follows the grant by at least 3 cycles.
// Backpressure: requests wait for a grant; stall withholds grants, flush drops or drains the in-flight access.
module mem_bus_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_bus_scheduler_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t                state, state_nxt;
    logic                  gnt0, gnt1;
    logic                  owner_q;        // 0 = fetch, 1 = MMU
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data0_q, data1_q;
    logic [SW-1:0]         starve_cnt;
    logic [TW-1:0]         tmo_cnt;
    logic                  err_q;
    logic                  tmo_hit;
    logic                  flush;

    assign flush   = bus.system_flush;
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Next-state and grant decode; grants only exist in IDLE and are forced low while reset is held.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            S_IDLE: begin
                if (reset_n && !flush && !bus.system_stall) begin
                    if (bus.req0_valid && (!bus.req1_valid || starve_cnt == STARVE_MAX)) begin
                        gnt0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        gnt1 = 1'b1;
                    end
                end
                if (gnt0 || gnt1) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = flush ? S_IDLE : S_BUSY;
            S_BUSY: begin
                // A flush coinciding with completion has nothing left to drain.
                if (flush) begin
                    state_nxt = (bus.mem_data_valid || tmo_hit) ? S_IDLE : S_DRAIN;
                end else if (bus.mem_data_valid || tmo_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            S_DRAIN: begin
                if (bus.mem_data_valid || tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Latch the winning request so requesters may move on after their grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt0 || gnt1) begin
            owner_q <= gnt1;
            we_q    <= gnt1 && bus.we_p1;
            addr_q  <= gnt1 ? bus.addr_p1 : bus.addr_p0;
            wdata_q <= gnt1 ? bus.data_p1_wrt : '0;
        end
    end

    // Timeout counter runs through BUSY and DRAIN, restarting with every issued transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state_nxt == S_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == S_BUSY || state == S_DRAIN) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Error flag for the RESP pulse: set only when BUSY gives up without a flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state_nxt == S_ISSUE) begin
            err_q <= 1'b0;
        end else if (state == S_BUSY && !flush && !bus.mem_data_valid && tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    // Read data capture into the owner's register; writes and drained responses leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data0_q <= '0;
            data1_q <= '0;
        end else if (state == S_BUSY && !flush && bus.mem_data_valid && !we_q) begin
            if (owner_q) data1_q <= bus.mem_rdata;
            else         data0_q <= bus.mem_rdata;
        end
    end

    // Starvation counter: counts every cycle a fetch request waits, saturating at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (gnt0 || !bus.req0_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign bus.grant0        = gnt0;
    assign bus.grant1        = gnt1;
    assign bus.mem_req_valid = (state == S_ISSUE) || (state == S_BUSY) || (state == S_DRAIN);
    assign bus.mem_addr      = addr_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.rvalid0       = (state == S_RESP) && !owner_q && !flush;
    assign bus.rvalid1       = (state == S_RESP) && owner_q && !flush;
    assign bus.err0          = bus.rvalid0 && err_q;
    assign bus.err1          = bus.rvalid1 && err_q;
    assign bus.data_p0       = data0_q;
    assign bus.data_p1_rd    = data1_q;
endmodule

// File: tb/tb_mem_bus_scheduler.sv
// Directed bench for mem_bus_scheduler: arbitration, starvation, timeout, flush and async reset.
// Inputs are driven 1 ns after the rising edge and outputs sampled 1-2 ns after it.
// Every check compares against hand-computed constants.
module tb_mem_bus_scheduler;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    mem_bus_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4), .TIMEOUT(256)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.system_flush   = 1'b0;
        bus.system_stall   = 1'b0;
        bus.req0_valid     = 1'b0;
        bus.addr_p0        = '0;
        bus.req1_valid     = 1'b0;
        bus.addr_p1        = '0;
        bus.we_p1          = 1'b0;
        bus.data_p1_wrt    = '0;
        bus.mem_rdata      = '0;
        bus.mem_data_valid = 1'b0;
    endtask

    // Called in the ISSUE cycle: memory answers in the first BUSY cycle, ends back in IDLE.
    task automatic run_txn(input logic [DW-1:0] rdata);
        tick();
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = rdata;
        tick();
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = '0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.req1_valid = 1'b1;
        #12;
        total++;
        if ({bus.grant0, bus.grant1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1,
             bus.mem_req_valid, bus.mem_we} !== 8'h00)
            begin bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.grant0, bus.grant1,
                bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, bus.mem_req_valid, bus.mem_we}); end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.data_p0, bus.data_p1_rd} !== 128'h0)
            begin bad++; $display("FAIL reset_data got=%h exp=0",
                {bus.mem_addr, bus.mem_wdata, bus.data_p0, bus.data_p1_rd}); end
        @(negedge clk);
        reset_n        = 1'b1;
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_fetch();
        bus.system_stall = 1'b1;
        bus.req0_valid   = 1'b1;
        bus.addr_p0      = 32'h100;
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b00)
            begin bad++; $display("FAIL stall_blocks got=%b exp=00", {bus.grant0, bus.grant1}); end
        tick();
        bus.system_stall = 1'b0;
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b10)
            begin bad++; $display("FAIL fetch_grant got=%b exp=10", {bus.grant0, bus.grant1}); end
        tick();                                     // ISSUE
        bus.req0_valid = 1'b0;
        bus.addr_p0    = 32'hFFFF_FFFF;
        total++;
        if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100})
            begin bad++; $display("FAIL fetch_issue got=%h exp=%h",
                {bus.mem_req_valid, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 32'h100}); end
        tick();                                     // BUSY 1
        tick();                                     // BUSY 2
        total++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.rvalid0} !== {1'b1, 32'h100, 1'b0})
            begin bad++; $display("FAIL fetch_busy_hold got=%h exp=%h",
                {bus.mem_req_valid, bus.mem_addr, bus.rvalid0}, {1'b1, 32'h100, 1'b0}); end
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        tick();                                     // RESP, 4 cycles after grant
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = '0;
        total++;
        if ({bus.rvalid0, bus.err0, bus.rvalid1, bus.mem_req_valid, bus.data_p0} !==
            {4'b1000, 32'hDEAD_BEEF})
            begin bad++; $display("FAIL fetch_resp got=%h exp=%h", {bus.rvalid0, bus.err0,
                bus.rvalid1, bus.mem_req_valid, bus.data_p0}, {4'b1000, 32'hDEAD_BEEF}); end
        tick();                                     // IDLE
        total++;
        if (bus.rvalid0 !== 1'b0)
            begin bad++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", bus.rvalid0); end
    endtask

    task automatic test_both();
        bus.req0_valid  = 1'b1;
        bus.addr_p0     = 32'h300;
        bus.req1_valid  = 1'b1;
        bus.addr_p1     = 32'h200;
        bus.we_p1       = 1'b1;
        bus.data_p1_wrt = 32'h55;
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b01)
            begin bad++; $display("FAIL both_grant1 got=%b exp=01", {bus.grant0, bus.grant1}); end
        tick();                                     // ISSUE
        bus.req1_valid  = 1'b0;
        bus.we_p1       = 1'b0;
        bus.data_p1_wrt = '0;
        total++;
        if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 32'h200, 32'h55})
            begin bad++; $display("FAIL both_write_issue got=%h exp=%h",
                {bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                {2'b11, 32'h200, 32'h55}); end
        tick();                                     // BUSY: write ack with junk on rdata
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = 32'hBAD0_0BAD;
        tick();                                     // RESP
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = '0;
        total++;
        if ({bus.rvalid1, bus.err1, bus.rvalid0, bus.data_p1_rd} !== {3'b100, 32'h0})
            begin bad++; $display("FAIL both_write_resp got=%h exp=%h",
                {bus.rvalid1, bus.err1, bus.rvalid0, bus.data_p1_rd}, {3'b100, 32'h0}); end
        tick();                                     // IDLE
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b10)
            begin bad++; $display("FAIL both_grant0_next got=%b exp=10", {bus.grant0, bus.grant1}); end
        tick();                                     // ISSUE
        bus.req0_valid = 1'b0;
        total++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h300})
            begin bad++; $display("FAIL both_fetch_issue got=%h exp=%h",
                {bus.mem_we, bus.mem_addr}, {1'b0, 32'h300}); end
        run_txn(32'h1234_5678);
        total++;
        if (bus.data_p0 !== 32'h1234_5678)
            begin bad++; $display("FAIL both_fetch_data got=%h exp=12345678", bus.data_p0); end
    endtask

    task automatic test_starve();
        bus.req0_valid = 1'b1;
        bus.addr_p0    = 32'h500;
        bus.req1_valid = 1'b1;
        bus.addr_p1    = 32'h600;
        bus.we_p1      = 1'b0;
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b01)
            begin bad++; $display("FAIL starve_round1 got=%b exp=01", {bus.grant0, bus.grant1}); end
        tick();
        run_txn(32'h1111_1111);                     // starve count reaches 4 by the next IDLE
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b10)
            begin bad++; $display("FAIL starve_forced_fetch got=%b exp=10", {bus.grant0, bus.grant1}); end
        tick();
        run_txn(32'hA5A5_A5A5);                     // count restarts at 0, only 3 by the next IDLE
        #1;
        total++;
        if ({bus.grant0, bus.grant1} !== 2'b01)
            begin bad++; $display("FAIL starve_cleared got=%b exp=01", {bus.grant0, bus.grant1}); end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        run_txn(32'hCAFE_0001);
        total++;
        if ({bus.data_p0, bus.data_p1_rd} !== {32'hA5A5_A5A5, 32'hCAFE_0001})
            begin bad++; $display("FAIL starve_data got=%h exp=%h",
                {bus.data_p0, bus.data_p1_rd}, {32'hA5A5_A5A5, 32'hCAFE_0001}); end
    endtask

    task automatic test_timeout();
        logic early;
        early          = 1'b0;
        bus.req1_valid = 1'b1;
        bus.addr_p1    = 32'h700;
        #1;
        total++;
        if (bus.grant1 !== 1'b1)
            begin bad++; $display("FAIL tmo_grant got=%b exp=1", bus.grant1); end
        tick();                                     // ISSUE
        bus.req1_valid = 1'b0;
        tick();                                     // BUSY 1
        for (int i = 0; i < 255; i++) begin
            if (bus.rvalid1 !== 1'b0 || bus.mem_req_valid !== 1'b1) early = 1'b1;
            tick();
        end
        total++;                                    // BUSY 256
        if ({early, bus.rvalid1, bus.mem_req_valid} !== 3'b001)
            begin bad++; $display("FAIL tmo_busy_hold got=%b exp=001",
                {early, bus.rvalid1, bus.mem_req_valid}); end
        tick();                                     // RESP
        total++;
        if ({bus.rvalid1, bus.err1, bus.rvalid0, bus.data_p1_rd} !== {3'b110, 32'hCAFE_0001})
            begin bad++; $display("FAIL tmo_resp got=%h exp=%h",
                {bus.rvalid1, bus.err1, bus.rvalid0, bus.data_p1_rd}, {3'b110, 32'hCAFE_0001}); end
        tick();                                     // IDLE
        bus.req0_valid = 1'b1;
        bus.addr_p0    = 32'h0;
        #1;
        total++;
        if ({bus.rvalid1, bus.err1, bus.grant0} !== 3'b001)
            begin bad++; $display("FAIL tmo_back_idle got=%b exp=001",
                {bus.rvalid1, bus.err1, bus.grant0}); end
        bus.req0_valid = 1'b0;                      // withdrawn before the edge
    endtask

    task automatic test_flush_busy();
        tick();
        bus.req0_valid = 1'b1;
        bus.addr_p0    = 32'h540;
        #1;
        total++;
        if (bus.grant0 !== 1'b1)
            begin bad++; $display("FAIL flush_grant got=%b exp=1", bus.grant0); end
        tick();                                     // ISSUE
        bus.req0_valid = 1'b0;
        tick();                                     // BUSY 1
        bus.system_flush = 1'b1;
        tick();                                     // DRAIN 1
        bus.system_flush = 1'b0;
        total++;
        if ({bus.mem_req_valid, bus.rvalid0, bus.mem_addr} !== {2'b10, 32'h540})
            begin bad++; $display("FAIL flush_drain_enter got=%h exp=%h",
                {bus.mem_req_valid, bus.rvalid0, bus.mem_addr}, {2'b10, 32'h540}); end
        bus.system_flush = 1'b1;                    // second flush while draining
        tick();                                     // DRAIN 2
        bus.system_flush = 1'b0;
        tick();                                     // DRAIN 3: memory finally answers
        total++;
        if ({bus.mem_req_valid, bus.rvalid0} !== 2'b10)
            begin bad++; $display("FAIL flush_drain_hold got=%b exp=10",
                {bus.mem_req_valid, bus.rvalid0}); end
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = 32'hBADB_AD00;
        tick();                                     // IDLE
        bus.mem_data_valid = 1'b0;
        bus.mem_rdata      = '0;
        total++;
        if ({bus.mem_req_valid, bus.rvalid0, bus.err0, bus.data_p0} !== {3'b000, 32'hA5A5_A5A5})
            begin bad++; $display("FAIL flush_no_resp got=%h exp=%h",
                {bus.mem_req_valid, bus.rvalid0, bus.err0, bus.data_p0}, {3'b000, 32'hA5A5_A5A5}); end
        bus.req1_valid = 1'b1;
        bus.addr_p1    = 32'h800;
        #1;
        total++;
        if (bus.grant1 !== 1'b1)
            begin bad++; $display("FAIL flush_next_grant got=%b exp=1", bus.grant1); end
        tick();
        bus.req1_valid = 1'b0;
        run_txn(32'h0BAD_F00D);
        total++;
        if (bus.data_p1_rd !== 32'h0BAD_F00D)
            begin bad++; $display("FAIL flush_next_data got=%h exp=0badf00d", bus.data_p1_rd); end
    endtask

    task automatic test_flush_resp();
        bus.req1_valid = 1'b1;
        bus.addr_p1    = 32'h900;
        tick();                                     // ISSUE
        bus.req1_valid = 1'b0;
        tick();                                     // BUSY
        bus.mem_data_valid = 1'b1;
        bus.mem_rdata      = 32'h1357_2468;
        tick();                                     // RESP with flush
        bus.mem_data_valid = 1'b0;
        bus.system_flush   = 1'b1;
        #1;
        total++;
        if ({bus.rvalid1, bus.err1} !== 2'b00)
            begin bad++; $display("FAIL flush_resp_suppress got=%b exp=00", {bus.rvalid1, bus.err1}); end
        tick();
        bus.system_flush = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.req1_valid  = 1'b1;
        bus.addr_p1     = 32'hA00;
        bus.we_p1       = 1'b1;
        bus.data_p1_wrt = 32'hFFFF_0000;
        tick();                                     // ISSUE
        bus.req1_valid = 1'b0;
        tick();                                     // BUSY 1
        bus.system_stall = 1'b1;
        bus.req1_valid   = 1'b1;
        #2;
        reset_n = 1'b0;                             // mid-cycle, no clock edge
        #1;
        total++;
        if ({bus.mem_req_valid, bus.mem_we, bus.grant0, bus.grant1, bus.rvalid0, bus.rvalid1,
             bus.err0, bus.err1} !== 8'h00)
            begin bad++; $display("FAIL areset_ctrl got=%b exp=0", {bus.mem_req_valid, bus.mem_we,
                bus.grant0, bus.grant1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1}); end
        total++;
        if ({bus.mem_addr, bus.mem_wdata, bus.data_p0, bus.data_p1_rd} !== 128'h0)
            begin bad++; $display("FAIL areset_data got=%h exp=0",
                {bus.mem_addr, bus.mem_wdata, bus.data_p0, bus.data_p1_rd}); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.grant1, bus.mem_req_valid} !== 2'b00)
            begin bad++; $display("FAIL areset_stall_hold got=%b exp=00",
                {bus.grant1, bus.mem_req_valid}); end
        bus.system_stall = 1'b0;
        #1;
        total++;
        if (bus.grant1 !== 1'b1)
            begin bad++; $display("FAIL areset_unstall_grant got=%b exp=1", bus.grant1); end
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_starve();
        test_timeout();
        test_flush_busy();
        test_flush_resp();
        test_async_reset();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_scheduler.md
Name: mem_bus_scheduler

Overview:
- Shares the single main-memory bus between the instruction fetch unit (port 0, read-only) and the MMU/load-store unit (port 1, read/write).
- One transaction is outstanding at a time.
- Arbitration gives the MMU fixed priority, with an anti-starvation override for fetch.
- Adds a response timeout and flush draining so no orphaned memory response ever reaches a requester.
- Sits between the core front/back ends and the CPU-top memory interface.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
STARVE_LIMIT, 4, cycles a pending fetch request may lose before it is forced to win
TIMEOUT, 256, max BUSY cycles waiting for mem_data_valid before error completion

Ports:
clk  in  1  system clock; all logic rising-edge
reset_n  in  1  asynchronous active-low reset
system_flush  in  1  pipeline flush, sampled synchronously
system_stall  in  1  blocks new grants
req0_valid  in  1  fetch request
addr_p0  in  ADDR_WIDTH  fetch address
grant0  out  1  fetch request accepted this cycle
data_p0  out  DATA_WIDTH  fetch read data
rvalid0  out  1  one-cycle pulse, data_p0 valid
req1_valid  in  1  MMU request
addr_p1  in  ADDR_WIDTH  MMU address
we_p1  in  1  MMU write enable
data_p1_wrt  in  DATA_WIDTH  MMU write data
grant1  out  1  MMU request accepted this cycle
data_p1_rd  out  DATA_WIDTH  MMU read data
rvalid1  out  1  one-cycle pulse, MMU read done or write acked
err1  out  1  one-cycle pulse with rvalid1 on timeout
err0  out  1  one-cycle pulse with rvalid0 on timeout
mem_req_valid  out  1  memory request
mem_addr  out  ADDR_WIDTH  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
mem_data_valid  in  1  memory completion (read data or write ack)

Behaviour:
- Reset (reset_n low, asynchronous):
  - State is IDLE.
  - All outputs are 0: grants, rvalids, errs, mem_*, data_p0, data_p1_rd.
  - Starve counter and timeout counter are 0.
- States: IDLE, ISSUE, BUSY, RESP, DRAIN.
- IDLE:
  - Grant logic is combinational in IDLE only, and only when !system_stall && !system_flush.
  - Default winner is port 1 whenever req1_valid is high.
  - Port 0 wins if only req0_valid is high, or if starve_cnt == STARVE_LIMIT.
  - Exactly one of grant0/grant1 is high; never both.
  - On the grant edge, latch addr, we (port 1 only; port 0 is always a read), wdata and owner, then go to ISSUE.
- ISSUE: drive mem_req_valid=1 with the latched addr/we/wdata; go to BUSY next cycle.
- BUSY:
  - Hold mem_req_valid and all mem_* stable.
  - On mem_data_valid: capture mem_rdata into the owner's data register (reads only; on a write the data register is unchanged) and go to RESP.
  - If the timeout counter reaches TIMEOUT-1 without mem_data_valid: flag an error, leave the data register unchanged, and go to RESP.
- RESP:
  - mem_req_valid=0.
  - Pulse the owner's rvalid, plus its err if timed out.
  - Go to IDLE.
  - The minimum grant-to-rvalid latency is 3 cycles (memory answering in the first BUSY cycle).
- Starve counter:
  - Increments on each cycle with req0_valid && !grant0, saturating at STARVE_LIMIT.
  - Clears on grant0 or when req0_valid is low.
- Timeout counter: counts BUSY/DRAIN cycles; clears on entry to ISSUE.
- system_flush:
  - From IDLE or ISSUE: go to IDLE. A latched-but-unissued request is dropped and no rvalid is produced.
  - From BUSY: go to DRAIN.
  - From RESP: the rvalid pulse is suppressed.
  - Flush overrides stall.
- DRAIN:
  - Keep mem_req_valid high until mem_data_valid or timeout, then go to IDLE.
  - No rvalid/err and no data-register update.
  - A further flush while in DRAIN has no effect.
- system_stall affects grant issue in IDLE only. In-flight transactions complete normally.
- Requesters must hold req/addr/data until they see their grant. After the grant they may change them freely.

Test Plan:
- Fetch only: req0 at addr 0x100, memory returns 0xDEADBEEF after 2 BUSY cycles -> grant0 pulse; mem_addr=0x100, mem_we=0; rvalid0 pulse with data_p0=0xDEADBEEF; 4 cycles grant-to-rvalid.
- Both request simultaneously: MMU write to 0x200 with data 0x55 -> grant1 first; mem_we=1, mem_wdata=0x55; rvalid1 with err1=0; then grant0 in the next IDLE.
- Starvation: req1 held continuously, req0 held -> after starve_cnt reaches 4, grant0 wins over req1; counter clears.
- Timeout: issue a read with mem_data_valid never asserted -> after 256 BUSY cycles, rvalid1 and err1 pulse together; data_p1_rd unchanged; state IDLE.
- Flush in BUSY: flush during fetch BUSY, memory responds 3 cycles later -> DRAIN holds mem_req_valid until then; no rvalid0; data_p0 unchanged; next grant possible the cycle after.
- Async reset mid-BUSY with stall high: reset_n dropped -> mem_req_valid and all outputs go to 0 immediately without a clock edge; after release with stall high, no grant is issued.
